// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer.
//   state_t              : frame sequencer states
//   ERR_LINE/GEOM/COUNT  : bit positions inside err_code
//   sobel_expected_count : number of outputs sobel_processor produces for
//                          a w x h frame. The 3x3 window loses two rows and
//                          one column of outputs.
package sobel_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      ACTIVE,
      DRAIN,
      DONE
   } state_t;

   localparam int ERR_LINE  = 0;
   localparam int ERR_GEOM  = 1;
   localparam int ERR_COUNT = 2;

   function automatic int sobel_expected_count(input int w, input int h);
      return (h - 2) * (w - 1);
   endfunction

endpackage

// File: rtl/sobel_geom_checker.sv
// Frame geometry checker for the Sobel frame sequencer.
// Keeps a registered copy of the camera syncs for edge detection, counts
// pixels per line and lines per frame, and flags line-length and geometry
// errors.
//   clk, rst_n     : clock, synchronous active-low reset
//   hold           : abort in progress; counters and flags freeze
//   state          : current sequencer state
//   cam_vsync/href : raw camera syncs
//   vsync_rise     : cam_vsync rising edge (combinational)
//   href_fall      : cam_href falling edge (combinational)
//   rows_done      : IMG_HEIGHT lines seen in the current frame
//   err_line       : some line was not exactly IMG_WIDTH pixels
//   err_geom       : early vsync or href seen while draining
module sobel_geom_checker
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 48
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   hold,
   input  state_t state,
   input  logic   cam_vsync,
   input  logic   cam_href,
   output logic   vsync_rise,
   output logic   href_fall,
   output logic   rows_done,
   output logic   err_line,
   output logic   err_geom
);

   localparam int COL_W = $clog2(IMG_WIDTH + 2);
   localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_WIDTH + 1);
   localparam logic [COL_W-1:0] COL_GOOD = COL_W'(IMG_WIDTH);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT);

   logic             vsync_p0;
   logic             href_p0;
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic             frame_start;

   assign vsync_rise  = cam_vsync & ~vsync_p0;
   assign href_fall   = ~cam_href & href_p0;
   assign rows_done   = (row_cnt == ROW_LAST);
   assign frame_start = (state == ARMED) && vsync_rise && !hold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_p0 <= 1'b0;
         href_p0  <= 1'b0;
         col_cnt  <= '0;
         row_cnt  <= '0;
         err_line <= 1'b0;
         err_geom <= 1'b0;
      end else begin
         // stage p0: registered copy of the camera syncs
         vsync_p0 <= cam_vsync;
         href_p0  <= cam_href;
         if (frame_start) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            err_line <= 1'b0;
            err_geom <= 1'b0;
         end else if (!hold) begin
            if (state == ACTIVE) begin
               // Saturating one past the nominal width still marks an
               // over-long line as wrong without wrapping back to a match.
               if (cam_href && col_cnt != COL_MAX)
                  col_cnt <= col_cnt + 1'b1;
               if (href_fall && !rows_done) begin
                  if (col_cnt != COL_GOOD)
                     err_line <= 1'b1;
                  row_cnt <= row_cnt + 1'b1;
                  col_cnt <= '0;
               end
               if (vsync_rise && !rows_done)
                  err_geom <= 1'b1;
            end
            if (state == DRAIN && cam_href)
               err_geom <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the camera capture port and sobel_processor.
// Arms on request, starts on a camera vsync rising edge, forwards the pixel
// stream with one register stage, latches the Sobel mode per frame, and
// reports per-frame done/error status.
//   clk, rst_n              : clock, synchronous active-low reset
//   start, abort            : arm for next frame / return to IDLE at once
//   continuous              : re-arm after each frame
//   enable_req              : requested Sobel mode, latched at frame start
//   cam_vsync/href/pixel    : camera input (RGB565)
//   proc_vsync/href/pixel   : registered stream to sobel_processor
//   proc_sobel_enable       : Sobel mode latched for the current frame
//   proc_valid              : sobel_processor output strobe
//   busy                    : sequencer not IDLE
//   frame_done, frame_err   : one-cycle end-of-frame pulses
//   err_code                : {count, geometry, line-length} errors
//   out_count, frame_count  : outputs this frame / completed frames
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH     = 64,
   parameter int IMG_HEIGHT    = 48,
   parameter int DRAIN_TIMEOUT = 256,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             continuous,
   input  logic             enable_req,
   input  logic             cam_vsync,
   input  logic             cam_href,
   input  logic [15:0]      cam_pixel,
   output logic             proc_vsync,
   output logic             proc_href,
   output logic [15:0]      proc_pixel,
   output logic             proc_sobel_enable,
   input  logic             proc_valid,
   output logic             busy,
   output logic             frame_done,
   output logic             frame_err,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] out_count,
   output logic [CNT_W-1:0] frame_count
);

   localparam int EXPECTED = sobel_expected_count(IMG_WIDTH, IMG_HEIGHT);
   localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECTED);
   localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_END = TMR_W'(DRAIN_TIMEOUT);

   state_t           state;
   state_t           state_nxt;
   logic             vsync_rise;
   logic             href_fall;
   logic             rows_done;
   logic             err_line;
   logic             err_geom;
   logic             err_cnt;
   logic             count_bad;
   logic             frame_start;
   logic             counting;
   logic [TMR_W-1:0] drain_tmr;

   sobel_geom_checker #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_geom (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold       (abort),
      .state      (state),
      .cam_vsync  (cam_vsync),
      .cam_href   (cam_href),
      .vsync_rise (vsync_rise),
      .href_fall  (href_fall),
      .rows_done  (rows_done),
      .err_line   (err_line),
      .err_geom   (err_geom)
   );

   assign frame_start = (state == ARMED) && vsync_rise && !abort;
   assign counting    = (state == ACTIVE) || (state == DRAIN) || (state == DONE);
   // A frame cut short by an early vsync is already a geometry error; its
   // output count is meaningless, so the count check only applies to frames
   // that delivered every line.
   assign count_bad   = rows_done && (out_count != EXP_CNT);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ARMED;
         ARMED:   if (vsync_rise) state_nxt = ACTIVE;
         ACTIVE: begin
            if (rows_done)
               state_nxt = DRAIN;
            else if (vsync_rise)
               state_nxt = DONE;
         end
         DRAIN:   if (out_count == EXP_CNT || drain_tmr == TMR_END) state_nxt = DONE;
         DONE:    state_nxt = continuous ? ARMED : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         proc_pixel        <= '0;
         proc_href         <= 1'b0;
         proc_vsync        <= 1'b0;
         proc_sobel_enable <= 1'b0;
         out_count         <= '0;
         frame_count       <= '0;
         err_cnt           <= 1'b0;
         drain_tmr         <= '0;
      end else begin
         // stage p0: forwarded stream
         proc_pixel <= cam_pixel;
         proc_href  <= !abort && (state == ACTIVE) && cam_href;
         proc_vsync <= !abort && ((state == ARMED) || (state == ACTIVE)) && cam_vsync;
         if (!abort) begin
            if (frame_start) begin
               proc_sobel_enable <= enable_req;
               out_count         <= '0;
               err_cnt           <= 1'b0;
            end else if (proc_valid && counting && out_count != '1) begin
               out_count <= out_count + 1'b1;
            end
            if (state == DRAIN)
               drain_tmr <= proc_valid ? '0 : drain_tmr + 1'b1;
            else
               drain_tmr <= '0;
            if (state == DONE) begin
               err_cnt     <= count_bad;
               frame_count <= frame_count + 1'b1;
            end
         end
      end
   end

   // The count bit is live during DONE and held afterwards until the next
   // frame start, so err_code is valid alongside frame_done.
   always_comb begin
      err_code            = '0;
      err_code[ERR_LINE]  = err_line;
      err_code[ERR_GEOM]  = err_geom;
      err_code[ERR_COUNT] = (state == DONE) ? count_bad : err_cnt;
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE) && !abort;
   assign frame_err  = frame_done && (|err_code);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             continuous = 1'b0;
   logic             enable_req = 1'b0;
   logic             cam_vsync = 1'b0;
   logic             cam_href = 1'b0;
   logic [15:0]      cam_pixel = '0;
   logic             proc_vsync;
   logic             proc_href;
   logic [15:0]      proc_pixel;
   logic             proc_sobel_enable;
   logic             proc_valid = 1'b0;
   logic             busy;
   logic             frame_done;
   logic             frame_err;
   logic [2:0]       err_code;
   logic [CNT_W-1:0] out_count;
   logic [CNT_W-1:0] frame_count;

   sobel_frame_ctrl #(
      .IMG_WIDTH     (64),
      .IMG_HEIGHT    (48),
      .DRAIN_TIMEOUT (256),
      .CNT_W         (CNT_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .abort             (abort),
      .continuous        (continuous),
      .enable_req        (enable_req),
      .cam_vsync         (cam_vsync),
      .cam_href          (cam_href),
      .cam_pixel         (cam_pixel),
      .proc_vsync        (proc_vsync),
      .proc_href         (proc_href),
      .proc_pixel        (proc_pixel),
      .proc_sobel_enable (proc_sobel_enable),
      .proc_valid        (proc_valid),
      .busy              (busy),
      .frame_done        (frame_done),
      .frame_err         (frame_err),
      .err_code          (err_code),
      .out_count         (out_count),
      .frame_count       (frame_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // sobel_processor stand-in: one valid per forwarded pixel, up to a limit
   // per frame; the per-frame tally restarts on each proc_vsync rise.
   int   stub_limit = 0;
   int   stub_sent = 0;
   int   last_valid_cyc = 0;
   logic pv_q = 1'b0;
   always @(posedge clk) begin
      #1;
      if (proc_vsync && !pv_q) stub_sent = 0;
      pv_q = proc_vsync;
      if (proc_href && stub_sent < stub_limit) begin
         proc_valid = 1'b1;
         stub_sent++;
         last_valid_cyc = cyc;
      end else begin
         proc_valid = 1'b0;
      end
   end

   // frame_done capture
   int         done_pulses = 0;
   logic [2:0] cap_err = '0;
   logic       cap_ferr = 1'b0;
   int         done_cyc = 0;
   always @(negedge clk) begin
      if (frame_done) begin
         done_pulses++;
         cap_err  = err_code;
         cap_ferr = frame_err;
         done_cyc = cyc;
      end
   end

   int n_vec = 0;
   int n_fail = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // One camera frame: 3 cycles vsync high, 3 low, then nrows lines of
   // 64 pixels (63 on bad_row) with 4 blanking cycles each. enable_req goes
   // to 1 at the start of en_row; abort is pulsed with the first pixel of
   // abort_row and the frame is abandoned there.
   task automatic run_frame(input int nrows, input int bad_row, input int budget,
                            input logic en, input int en_row, input int abort_row);
      int len;
      stub_limit = budget;
      enable_req = en;
      cam_vsync  = 1'b1;
      repeat (3) tick();
      cam_vsync  = 1'b0;
      repeat (3) tick();
      for (int r = 0; r < nrows; r++) begin
         if (r == en_row) enable_req = 1'b1;
         if (r == abort_row) begin
            cam_href = 1'b1;
            abort    = 1'b1;
            tick();
            abort    = 1'b0;
            cam_href = 1'b0;
            return;
         end
         len = (r == bad_row) ? 63 : 64;
         for (int p = 0; p < len; p++) begin
            cam_href  = 1'b1;
            cam_pixel = 16'((r * 64 + p) ^ 16'hA5C3);
            tick();
         end
         cam_href = 1'b0;
         repeat (4) tick();
      end
   endtask

   task automatic wait_done(input string nm, input int prev, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (done_pulses > prev) break;
         tick();
      end
      check({nm, "_done_pulses"}, done_pulses - prev, 1);
   endtask

   typedef struct {
      string      name;
      int         bad_row;
      int         budget;
      logic       en;
      int         en_row;
      logic [2:0] exp_err;
      int         exp_out;
      bit         chk_to;
   } vec_t;

   vec_t vecs[5];
   int   exp_fc = 0;
   int   prev;

   initial begin
      vecs[0] = '{"nominal",    -1, 2898, 1'b1, -1, 3'b000, 2898, 1'b0};
      vecs[1] = '{"short_line", 10, 2898, 1'b1, -1, 3'b001, 2898, 1'b0};
      vecs[2] = '{"few_valid",  -1, 2000, 1'b0, -1, 3'b100, 2000, 1'b1};
      vecs[3] = '{"en_midframe",-1, 2898, 1'b0, 20, 3'b000, 2898, 1'b0};
      vecs[4] = '{"en_next",    -1, 2898, 1'b1, -1, 3'b000, 2898, 1'b0};

      // reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_out_count", out_count, 0);
      check("rst_err_code", err_code, 0);
      check("rst_proc_pixel", proc_pixel, 0);
      rst_n = 1'b1;
      tick();

      // table-driven single frames
      for (int v = 0; v < 5; v++) begin
         prev = done_pulses;
         pulse_start();
         check({vecs[v].name, "_armed_busy"}, busy, 1);
         run_frame(48, vecs[v].bad_row, vecs[v].budget, vecs[v].en, vecs[v].en_row, -1);
         wait_done(vecs[v].name, prev, 1000);
         exp_fc++;
         repeat (2) tick();
         @(negedge clk);
         check({vecs[v].name, "_err_code"}, cap_err, vecs[v].exp_err);
         check({vecs[v].name, "_frame_err"}, cap_ferr, vecs[v].exp_err != 0);
         check({vecs[v].name, "_out_count"}, out_count, vecs[v].exp_out);
         check({vecs[v].name, "_frame_count"}, frame_count, exp_fc);
         check({vecs[v].name, "_busy"}, busy, 0);
         check({vecs[v].name, "_sobel_en"}, proc_sobel_enable, vecs[v].en);
         if (vecs[v].chk_to)
            check({vecs[v].name, "_drain_gap_ge_256"}, (done_cyc - last_valid_cyc) >= 256, 1);
      end

      // early vsync after 30 lines, continuous mode, then a clean frame
      continuous = 1'b1;
      pulse_start();
      run_frame(30, -1, 2898, 1'b0, -1, -1);
      prev = done_pulses;
      cam_vsync = 1'b1;
      @(negedge clk);
      check("geom_no_done_yet", frame_done, 0);
      @(negedge clk);
      check("geom_frame_done", frame_done, 1);
      check("geom_err_code", err_code, 3'b010);
      check("geom_frame_err", frame_err, 1);
      exp_fc++;
      tick();
      cam_vsync = 1'b0;
      repeat (3) tick();
      prev = done_pulses;
      run_frame(48, -1, 2898, 1'b1, -1, -1);
      wait_done("cont", prev, 1000);
      exp_fc++;
      repeat (2) tick();
      @(negedge clk);
      check("cont_err_code", cap_err, 3'b000);
      check("cont_out_count", out_count, 2898);
      check("cont_frame_count", frame_count, exp_fc);
      check("cont_rearmed_busy", busy, 1);
      continuous = 1'b0;
      tick();
      pulse_abort();
      @(negedge clk);
      check("cont_abort_idle", busy, 0);

      // abort at row 25
      tick();
      prev = done_pulses;
      pulse_start();
      run_frame(48, -1, 2898, 1'b0, -1, 25);
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_proc_href", proc_href, 0);
      check("abort_proc_vsync", proc_vsync, 0);
      check("abort_out_count_held", out_count, 1600);
      repeat (300) tick();
      check("abort_no_done", done_pulses - prev, 0);
      check("abort_frame_count", frame_count, exp_fc);

      // synchronous reset while draining
      pulse_start();
      prev = done_pulses;
      run_frame(48, -1, 1000, 1'b1, -1, -1);
      check("drain_still_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst2_busy", busy, 0);
      check("rst2_out_count", out_count, 0);
      check("rst2_frame_count", frame_count, 0);
      check("rst2_err_code", err_code, 0);
      check("rst2_sobel_en", proc_sobel_enable, 0);
      check("rst2_proc_vsync", proc_vsync, 0);
      check("rst2_proc_href", proc_href, 0);
      check("rst2_frame_done", frame_done, 0);
      repeat (300) tick();
      check("rst2_no_done", done_pulses - prev, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
